rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (we, wr_addr, wr_data) between two writeback requesters: channel A (ALU result) and channel B (load/immediate).
- Each channel has a one-entry holding buffer with a valid/ready handshake.
- A 2-way round-robin arbiter commits one buffered write per cycle.
- Exports a per-register pending mask so decode can stall on read-after-write hazards.

Parameters:
- DW, 4, data width (matches register width)
- AW, 2, register address width; NREGS = 2**AW = 4

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- a_valid  in  1  channel A write request
- a_ready  out  1  channel A can accept this cycle
- a_addr  in  AW  channel A destination register
- a_data  in  DW  channel A write data
- b_valid  in  1  channel B write request
- b_ready  out  1  channel B can accept this cycle
- b_addr  in  AW  channel B destination register
- b_data  in  DW  channel B write data
- rf_we  out  1  register file write enable
- rf_wr_addr  out  AW  register file write address
- rf_wr_data  out  DW  register file write data
- busy  out  NREGS  bit i = a buffered write to register i has not yet committed

Behaviour:
- State: bufA {v, addr, data}, bufB {v, addr, data}, last_grant (A/B).
- Reset (rst_n=0 at clk edge):
  - bufA.v = bufB.v = 0; last_grant = B, so A has first priority.
  - Outputs during reset: rf_we=0, rf_wr_addr=0, rf_wr_data=0, busy=0, a_ready=b_ready=1.
- Reset mid-operation drops uncommitted buffered writes; no partial write occurs.
- Grant (combinational from buffers):
  - Only one buffer valid: grant it.
  - Both valid: grant the channel != last_grant.
  - Neither valid: no grant, rf_we=0.
- Write port (combinational):
  - rf_we = grant present.
  - rf_wr_addr/rf_wr_data = granted buffer contents; 0 when no grant.
  - Register file commits at the end of the same cycle.
- Ready: x_ready = !bufX.v || grant==X. A buffer being drained may be refilled in the same cycle.
- Accept: x_valid && x_ready captures addr/data into bufX at the clock edge.
- Buffer update: granted buffer clears unless refilled the same edge. last_grant updates only when a grant occurs.
- Latency: request accepted in cycle N appears on rf_* in cycle N+1 at the earliest. Uncontended throughput is 1/cycle per channel.
- Contention: both channels continuously valid produces strict alternation A,B,A,B; worst-case wait is 1 extra cycle.
- Same destination in both buffers: commit order follows grant order; the later grant wins the final value.
- busy[i] = (bufA.v && bufA.addr==i) || (bufB.v && bufB.addr==i). It is computed from registered state only, so it stays high through the commit cycle.
- x_valid deasserted while x_ready=0: the request is simply not accepted; data is not held. Requesters must hold valid/addr/data until accepted.

Optional Feature:
- Macro: RF_WB_CONFLICT_CNT_EN
- Defined:
  - Adds output conflict_cnt [7:0].
  - Increments each cycle both buffers are valid.
  - Saturates at 255 and resets to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package rf_pkg:
  - RF_DW=4, RF_AW=2, RF_NREGS=4
  - typedef rf_wr_req_t {addr, data}
  - typedef enum grant_t {GNT_NONE, GNT_A, GNT_B}
- Sub-module rr_arb2:
  - Inputs: req[1:0], last_grant.
  - Output: one-hot gnt.
  - Purely combinational; last_grant stays in the parent.
- Buffers, busy decode and the optional counter stay in rf_wb_arbiter.

Test Plan:
- Reset, then idle -> rf_we=0, busy=0000, a_ready=b_ready=1 for 5 cycles.
- Single A write, addr=2, data=4'hA, cycle N:
  - Cycle N+1: rf_we=1, rf_wr_addr=2, rf_wr_data=A, busy=0100.
  - Cycle N+2: busy=0000.
- A (r1, 3) and B (r3, 5) accepted in the same cycle after reset:
  - Next cycle: grant A (r1, 3).
  - Following cycle: grant B (r3, 5).
  - b_ready=0 for one cycle only.
- Both channels valid for 8 cycles, incrementing data -> rf_we every cycle, grants alternate A,B,A,B…, no data lost or reordered within a channel.
- A and B both target r0 (A=4'h1, B=4'h7), simultaneous -> commits 1 then 7; final r0=7; busy[0] clears only after the second commit.
- Assert rst_n=0 while both buffers are full -> next cycle rf_we=0, busy=0. After release, the next A+B conflict grants A first.
- With RF_WB_CONFLICT_CNT_EN, hold both channels valid for 300 cycles -> conflict_cnt saturates at 255; reset returns it to 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and sizing for the register-file writeback arbiter.
package rf_pkg;

  localparam int RF_DW    = 4;
  localparam int RF_AW    = 2;
  localparam int RF_NREGS = 2 ** RF_AW;

  // One register-file write request.
  typedef struct packed {
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } rf_wr_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: req[0] = channel A, req[1] = channel B.
// Purely combinational; the owner keeps last_grant.
module rr_arb2
  import rf_pkg::*;
(
  input  logic [1:0] req,
  input  grant_t     last_grant,
  output logic [1:0] gnt
);

  // Lone requester wins; on contention the channel not granted last time wins.
  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == GNT_A) ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port sharer: two one-entry writeback buffers (A = ALU,
// B = load/immediate) drained one per cycle by a round-robin arbiter, plus a
// per-register pending mask for RAW-hazard stalls in decode.
// Optional: define RF_WB_CONFLICT_CNT_EN to add the saturating conflict_cnt output.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DW = RF_DW,
  parameter int AW = RF_AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [AW-1:0]        a_addr,
  input  logic [DW-1:0]        a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [AW-1:0]        b_addr,
  input  logic [DW-1:0]        b_data,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_wr_addr,
  output logic [DW-1:0]        rf_wr_data,
  output logic [(2**AW)-1:0]   busy
`ifdef RF_WB_CONFLICT_CNT_EN
  ,
  output logic [7:0]           conflict_cnt
`endif
);

  localparam int NREGS = 2 ** AW;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_buf_t;

  wb_buf_t    bufa_q;
  wb_buf_t    bufb_q;
  grant_t     last_grant_q;
  logic [1:0] gnt;
  logic       a_acc;
  logic       b_acc;

  rr_arb2 u_arb (
    .req        ({bufb_q.v, bufa_q.v}),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  // Outputs are forced to their idle values while rst_n is low so a reset
  // asserted over full buffers never lets a write reach the register file.
  always_comb begin
    rf_we      = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    if (rst_n) begin
      if (gnt[0]) begin
        rf_we      = 1'b1;
        rf_wr_addr = bufa_q.addr;
        rf_wr_data = bufa_q.data;
      end else if (gnt[1]) begin
        rf_we      = 1'b1;
        rf_wr_addr = bufb_q.addr;
        rf_wr_data = bufb_q.data;
      end
    end
  end

  // A buffer can take a new request when empty or when it drains this cycle.
  always_comb begin
    a_ready = !rst_n || !bufa_q.v || gnt[0];
    b_ready = !rst_n || !bufb_q.v || gnt[1];
    a_acc   = a_valid && a_ready;
    b_acc   = b_valid && b_ready;
  end

  // Pending-write mask decoded from the registered buffers only.
  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      busy[i] = rst_n &&
                ((bufa_q.v && (bufa_q.addr == AW'(i))) ||
                 (bufb_q.v && (bufb_q.addr == AW'(i))));
    end
  end

  // Buffer capture/drain and round-robin history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bufa_q       <= '0;
      bufb_q       <= '0;
      last_grant_q <= GNT_B;
    end else begin
      if (a_acc)       bufa_q <= '{v: 1'b1, addr: a_addr, data: a_data};
      else if (gnt[0]) bufa_q.v <= 1'b0;

      if (b_acc)       bufb_q <= '{v: 1'b1, addr: b_addr, data: b_data};
      else if (gnt[1]) bufb_q.v <= 1'b0;

      if (gnt[0])      last_grant_q <= GNT_A;
      else if (gnt[1]) last_grant_q <= GNT_B;
    end
  end

`ifdef RF_WB_CONFLICT_CNT_EN
  // Count cycles with both buffers occupied, saturating at 255.
  always_ff @(posedge clk) begin
    if (!rst_n)
      conflict_cnt <= '0;
    else if (bufa_q.v && bufb_q.v && (conflict_cnt != 8'hFF))
      conflict_cnt <= conflict_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed stimulus pushes expected
// commits; a negedge monitor pops and compares every rf_we cycle.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready;
  logic [1:0] a_addr, b_addr;
  logic [3:0] a_data, b_data;
  logic       rf_we;
  logic [1:0] rf_wr_addr;
  logic [3:0] rf_wr_data;
  logic [3:0] busy;
`ifdef RF_WB_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt;
`endif

  int         n_vec = 0;
  int         n_err = 0;
  rf_wr_req_t exp_q[$];
  logic [3:0] rf_model [4];

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DW(4), .AW(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .rf_we      (rf_we),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .busy       (busy)
`ifdef RF_WB_CONFLICT_CNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    rf_wr_req_t e;
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got write r%0d=%0h, required no write (t=%0t)",
                 rf_wr_addr, rf_wr_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_addr", 32'(rf_wr_addr), 32'(e.addr));
        check("sb_data", 32'(rf_wr_data), 32'(e.data));
        rf_model[rf_wr_addr] = rf_wr_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("rst_we",   32'(rf_we), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_addr", 32'(rf_wr_addr), 0);
      check("rst_data", 32'(rf_wr_data), 0);
      check("rst_ardy", 32'(a_ready), 1);
      check("rst_brdy", 32'(b_ready), 1);
      tick();
    end
    rst_n = 1'b1;
  endtask

  task automatic put_a(input logic [1:0] ad, input logic [3:0] d);
    a_valid = 1'b1; a_addr = ad; a_data = d;
  endtask

  task automatic put_b(input logic [1:0] ad, input logic [3:0] d);
    b_valid = 1'b1; b_addr = ad; b_data = d;
  endtask

  // Both channels held valid; expects strict A,B alternation starting with A.
  task automatic contend(input int n, input logic [1:0] aa, input logic [1:0] ba);
    int   ai, bi, cyc;
    logic ra, rb;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(rf_wr_req_t'{aa, 4'(k)});
      exp_q.push_back(rf_wr_req_t'{ba, 4'(k + 8)});
    end
    ai = 0; bi = 0; cyc = 0;
    put_a(aa, 4'd0);
    put_b(ba, 4'd8);
    while ((ai < n || bi < n) && cyc < 4 * n + 10) begin
      @(negedge clk);
      ra = a_ready;
      rb = b_ready;
      if (cyc > 0) check("contend_we", 32'(rf_we), 1);
      tick();
      if (a_valid && ra) ai++;
      if (b_valid && rb) bi++;
      a_valid = (ai < n); a_data = 4'(ai);
      b_valid = (bi < n); b_data = 4'(bi + 8);
      cyc++;
    end
    if (ai < n || bi < n) check("contend_timeout", 0, 1);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    for (int r = 0; r < 4; r++) rf_model[r] = '0;
    tick();

    // Reset then idle.
    do_reset(3);
    repeat (5) begin
      @(negedge clk);
      check("idle_we",   32'(rf_we), 0);
      check("idle_busy", 32'(busy), 0);
      check("idle_ardy", 32'(a_ready), 1);
      check("idle_brdy", 32'(b_ready), 1);
      tick();
    end

    // Single A write r2 = A.
    put_a(2'd2, 4'hA);
    exp_q.push_back(rf_wr_req_t'{2'd2, 4'hA});
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    check("single_we",   32'(rf_we), 1);
    check("single_busy", 32'(busy), 32'b0100);
    tick();
    @(negedge clk);
    check("single_busy_clr", 32'(busy), 0);
    check("single_we_clr",   32'(rf_we), 0);
    tick();

    // Simultaneous A(r1,3) / B(r3,5) after reset: A first.
    do_reset(1);
    put_a(2'd1, 4'd3);
    put_b(2'd3, 4'd5);
    exp_q.push_back(rf_wr_req_t'{2'd1, 4'd3});
    exp_q.push_back(rf_wr_req_t'{2'd3, 4'd5});
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    check("pair_brdy0", 32'(b_ready), 0);
    check("pair_ardy",  32'(a_ready), 1);
    check("pair_busy0", 32'(busy), 32'b1010);
    tick();
    @(negedge clk);
    check("pair_brdy1", 32'(b_ready), 1);
    check("pair_busy1", 32'(busy), 32'b1000);
    tick();
    @(negedge clk);
    check("pair_busy2", 32'(busy), 0);
    tick();

    // Sustained contention, 8 writes per channel.
    contend(8, 2'd2, 2'd3);
    repeat (3) tick();
    @(negedge clk);
    check("contend_drain", 32'(exp_q.size()), 0);
    tick();

    // Same destination r0: A=1 then B=7.
    put_a(2'd0, 4'h1);
    put_b(2'd0, 4'h7);
    exp_q.push_back(rf_wr_req_t'{2'd0, 4'h1});
    exp_q.push_back(rf_wr_req_t'{2'd0, 4'h7});
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    check("same_busy0", 32'(busy[0]), 1);
    tick();
    @(negedge clk);
    check("same_busy1", 32'(busy[0]), 1);
    tick();
    @(negedge clk);
    check("same_busy2", 32'(busy[0]), 0);
    check("same_r0",    32'(rf_model[0]), 32'h7);
    tick();

    // Reset with both buffers full drops both writes.
    put_a(2'd1, 4'd2);
    put_b(2'd2, 4'd3);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_we_in", 32'(rf_we), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_we",   32'(rf_we), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_ardy", 32'(a_ready), 1);
    tick();

    // First conflict after reset grants A.
    put_a(2'd1, 4'd9);
    put_b(2'd2, 4'd6);
    exp_q.push_back(rf_wr_req_t'{2'd1, 4'd9});
    exp_q.push_back(rf_wr_req_t'{2'd2, 4'd6});
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    check("postrst_brdy", 32'(b_ready), 0);
    check("postrst_addr", 32'(rf_wr_addr), 1);
    repeat (3) tick();

`ifdef RF_WB_CONFLICT_CNT_EN
    contend(160, 2'd0, 2'd1);
    @(negedge clk);
    check("cnt_sat", 32'(conflict_cnt), 255);
    repeat (4) tick();
    do_reset(1);
    @(negedge clk);
    check("cnt_rst", 32'(conflict_cnt), 0);
    tick();
`endif

    @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
